// File: rtl/timer_counter_pkg.sv
// Shared register-map, state and mode codes for the memory-mapped countdown timer.
// Imported by every timer instance and by the CPU top.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_RSVD2   = 2'b10,
    MODE_RSVD3   = 2'b11
  } mode_t;

  // CTRL bit layout: [3] IM, [2:1] MODE, [0] EN
  typedef struct packed {
    logic  im;
    mode_t mode;
    logic  en;
  } ctrl_t;

  localparam logic [1:0] OFF_CTRL   = 2'b00;
  localparam logic [1:0] OFF_PRESET = 2'b01;
  localparam logic [1:0] OFF_COUNT  = 2'b10;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer with CTRL/PRESET/COUNT registers and a maskable interrupt line.
// Auto-reload (MODE 01) exists only when TIMER_AUTORELOAD_EN is defined; otherwise every mode is one-shot.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  state_t      state;
  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        unused_bits;

  assign wr_ctrl     = we && (addr[3:2] == OFF_CTRL);
  assign wr_preset   = we && (addr[3:2] == OFF_PRESET);
  assign unused_bits = ^{addr[31:4], addr[1:0], din[31:4]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (ctrl.en) state <= ST_LOAD;
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl.en) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
`ifdef TIMER_AUTORELOAD_EN
          if (ctrl.mode == MODE_RELOAD) begin
            irq_flag <= 1'b0;
            state    <= ST_LOAD;
          end else begin
            ctrl.en <= 1'b0;
            state   <= ST_IDLE;
          end
`else
          ctrl.en <= 1'b0;
          state   <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase

      // Software writes come last so they override same-cycle FSM updates.
      if (wr_ctrl) begin
        ctrl     <= ctrl_t'(din[3:0]);
        irq_flag <= 1'b0;
      end
      if (wr_preset) begin
        preset   <= din;
        irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr[3:2])
      OFF_CTRL:   dout = {28'd0, ctrl};
      OFF_PRESET: dout = preset;
      OFF_COUNT:  dout = count;
      default:    dout = '0;
    endcase
  end

  assign irq = ctrl.im & irq_flag;

endmodule
